multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: INSTRET_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instruction register bits [6:0].
REQ-005 funct3  input  3  instruction register bits [14:12].
REQ-006 funct7b5  input  1  instruction register bit 30.
REQ-007 zero  input  1  ALU zero flag, valid in EXEC.
REQ-008 mem_ready  input  1  memory completed current request this cycle.
REQ-009 mem_req / mem_wr / addr_sel  output  1 each  memory enable, write, address source (0=PC, 1=ALU result).
REQ-010 ir_we / pc_we / reg_we  output  1 each  instruction-register, PC and register-file write enables.
REQ-011 pc_src  output  2  PC source: 0=PC+4, 1=branch target, 2=jump target.
REQ-012 wb_sel  output  2  register write data: 0=ALU, 1=memory, 2=PC+4.
REQ-013 alu_src_b / alu_op  output  1 / 3  ALU operand B source (0=rs2, 1=immediate) and ALU control code.
REQ-014 createdump / halted / instret  output  1 / 1 / INSTRET_W  memory dump pulse, halt status, retired count.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; Moore-decoded outputs, except pc_we in EXEC, which depends on zero.
REQ-016 FETCH: mem_req=1, mem_wr=0, addr_sel=0; hold until mem_ready; in the mem_ready cycle ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
REQ-017 DECODE: one cycle, no enables asserted; opcode 1111111 goes to HALT, recognized opcodes go to EXEC, any other opcode goes to HALT.
REQ-018 Recognized opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111.
REQ-019 EXEC R/I-ALU: alu_op from funct3 (plus funct7b5 for SUB/SRL on R), alu_src_b=(I-ALU); next state WB.
REQ-020 EXEC LOAD/STORE: alu_op=ADD, alu_src_b=1; next state MEM.
REQ-021 EXEC BRANCH: alu_op=SUB; pc_we=zero for funct3=000 and pc_we=~zero for funct3=001 (other funct3 never taken), pc_src=1; next state FETCH.
REQ-022 EXEC JAL: pc_we=1, pc_src=2, reg_we=1, wb_sel=2; next state FETCH.
REQ-023 MEM: mem_req=1, addr_sel=1, mem_wr=(STORE); hold until mem_ready; STORE then goes to FETCH, LOAD to WB.
REQ-024 WB: reg_we=1, wb_sel=1 for LOAD and 0 otherwise; next state FETCH.
REQ-025 instret SHALL increment by 1, wrapping modulo 2^INSTRET_W, on the last cycle of each completed instruction (transition into FETCH); HALT does not count.
REQ-026 On entry to HALT, createdump SHALL pulse for exactly one cycle; halted=1 thereafter; HALT is left only by rst; all enables 0 in HALT.
REQ-027 mem_ready asserted outside FETCH/MEM SHALL be ignored.
REQ-028 No more than one of ir_we, reg_we and the memory write (mem_req with mem_wr) SHALL be active in the same cycle, except ir_we with pc_we in FETCH.

Reset
REQ-029 While rst=1, all outputs SHALL be 0; on the clock edge where rst=1, state becomes FETCH and instret becomes 0.
REQ-030 Reset mid-FETCH/MEM SHALL abandon the request with no write; mem_req is deasserted while rst=1.

Structure
REQ-031 The shared package SHALL hold the state enum, opcode constants, the 3-bit ALU codes (ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SLL=110, SRL=111), and the pc_src/wb_sel encodings.
REQ-032 One sub-module, alu_op_decode (combinational mapping of opcode/funct3/funct7b5 to alu_op), SHALL be instantiated.

Verification
REQ-033 R-type ADD, mem_ready=1 immediately: FETCH,DECODE,EXEC,WB; reg_we=1 and wb_sel=0 in cycle 4; instret 0->1.
REQ-034 LOAD with mem_ready delayed 3 cycles in MEM: mem_req held 4 cycles with addr_sel=1 and mem_wr=0; then WB with wb_sel=1.
REQ-035 BEQ with zero=1 gives pc_we=1 and pc_src=1 in EXEC; BEQ with zero=0 gives pc_we=0; both return to FETCH.
REQ-036 Opcode 1111111: createdump high exactly 1 cycle, halted=1, no further mem_req for 20 cycles; rst releases to FETCH.
REQ-037 rst asserted mid-MEM STORE: mem_req=0 while rst=1, no write occurs, state is FETCH after reset and instret=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes,
// ALU control codes, mux encodings and the opcode classifier.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Instruction class latched in DECODE so later states do not re-decode.
  typedef enum logic [2:0] {
    IC_R       = 3'd0,
    IC_IALU    = 3'd1,
    IC_LOAD    = 3'd2,
    IC_STORE   = 3'd3,
    IC_BRANCH  = 3'd4,
    IC_JAL     = 3'd5,
    IC_HALT    = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_e;

  function automatic iclass_e classify_opcode(input logic [6:0] opcode);
    iclass_e ic;
    case (opcode)
      OP_R:      ic = IC_R;
      OP_IALU:   ic = IC_IALU;
      OP_LOAD:   ic = IC_LOAD;
      OP_STORE:  ic = IC_STORE;
      OP_BRANCH: ic = IC_BRANCH;
      OP_JAL:    ic = IC_JAL;
      OP_HALT:   ic = IC_HALT;
      default:   ic = IC_ILLEGAL;
    endcase
    return ic;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control: maps opcode/funct3/funct7b5 to a 3-bit ALU code.
// Address and jump arithmetic use ADD, branches compare with SUB.
module alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_op
);

  // Select the ALU operation for the current instruction
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_R, OP_IALU: begin
        case (funct3)
          3'b000: begin
            // funct7b5 selects SUB only for register-register; on I-ALU it is an immediate bit
            if ((opcode == OP_R) && funct7b5) begin
              alu_op = ALU_SUB;
            end else begin
              alu_op = ALU_ADD;
            end
          end
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLT;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_BRANCH: alu_op = ALU_SUB;
      OP_LOAD, OP_STORE, OP_JAL: alu_op = ALU_ADD;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with
// Moore-decoded datapath controls and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic                 addr_sel,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 reg_we,
  output logic [1:0]           pc_src,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 createdump,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  state_e               state_q, state_d;
  iclass_e              iclass_q, iclass_d;
  iclass_e              decode_class;
  logic                 dump_done_q, dump_done_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic [2:0]           alu_op_dec;

  alu_op_decode u_alu_op_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_op   (alu_op_dec)
  );

  assign decode_class = classify_opcode(opcode);

  // State, instruction class, dump flag and retired count with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      iclass_q    <= IC_ILLEGAL;
      dump_done_q <= 1'b0;
      instret_q   <= {INSTRET_W{1'b0}};
    end else begin
      state_q     <= state_d;
      iclass_q    <= iclass_d;
      dump_done_q <= dump_done_d;
      instret_q   <= instret_d;
    end
  end

  // Next-state logic; mem_ready is only looked at in FETCH and MEM
  always_comb begin
    state_d     = state_q;
    iclass_d    = iclass_q;
    dump_done_d = dump_done_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        iclass_d = decode_class;
        if ((decode_class == IC_HALT) || (decode_class == IC_ILLEGAL)) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (iclass_q)
          IC_R, IC_IALU:      state_d = ST_WB;
          IC_LOAD, IC_STORE:  state_d = ST_MEM;
          IC_BRANCH, IC_JAL:  state_d = ST_FETCH;
          default:            state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (iclass_q == IC_STORE) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        // Only reset leaves HALT; the flag marks the dump pulse as spent
        state_d     = ST_HALT;
        dump_done_d = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Count an instruction as retired on the cycle that returns to FETCH
  always_comb begin
    instret_d = instret_q;
    if ((state_q != ST_FETCH) && (state_d == ST_FETCH)) begin
      instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  // Datapath controls decoded from state; everything forced low during reset
  always_comb begin
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    pc_src     = PC_SRC_PLUS4;
    wb_sel     = WB_SEL_ALU;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    createdump = 1'b0;
    halted     = 1'b0;
    instret    = {INSTRET_W{1'b0}};
    if (rst) begin
      instret = {INSTRET_W{1'b0}};
    end else begin
      instret = instret_q;
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          addr_sel = 1'b0;
          pc_src   = PC_SRC_PLUS4;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end else begin
            ir_we = 1'b0;
            pc_we = 1'b0;
          end
        end
        ST_DECODE: begin
          mem_req = 1'b0;
        end
        ST_EXEC: begin
          alu_op = alu_op_dec;
          case (iclass_q)
            IC_IALU, IC_LOAD, IC_STORE: begin
              alu_src_b = 1'b1;
            end
            IC_BRANCH: begin
              pc_src = PC_SRC_BRANCH;
              case (funct3)
                F3_BEQ:  pc_we = zero;
                F3_BNE:  pc_we = ~zero;
                default: pc_we = 1'b0;
              endcase
            end
            IC_JAL: begin
              pc_we  = 1'b1;
              pc_src = PC_SRC_JUMP;
              reg_we = 1'b1;
              wb_sel = WB_SEL_PC4;
            end
            default: begin
              alu_src_b = 1'b0;
            end
          endcase
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_wr   = (iclass_q == IC_STORE);
        end
        ST_WB: begin
          reg_we = 1'b1;
          if (iclass_q == IC_LOAD) begin
            wb_sel = WB_SEL_MEM;
          end else begin
            wb_sel = WB_SEL_ALU;
          end
        end
        ST_HALT: begin
          halted     = 1'b1;
          createdump = ~dump_done_q;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written
// sequences for reset, halt and counter wrap.
module tb_multicycle_ctrl;

  localparam int IW = 4;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LD  = 7'b0000011;
  localparam logic [6:0] T_ST  = 7'b0100011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_HLT = 7'b1111111;

  // Output word: {mem_req, mem_wr, addr_sel, ir_we, pc_we, reg_we,
  //               pc_src[1:0], wb_sel[1:0], alu_src_b, alu_op[2:0], createdump, halted}
  localparam logic [15:0] E_FETCH_RDY  = 16'h9800;
  localparam logic [15:0] E_FETCH_WAIT = 16'h8000;
  localparam logic [15:0] E_NONE       = 16'h0000;
  localparam logic [15:0] E_WB_ALU     = 16'h0400;
  localparam logic [15:0] E_WB_MEM     = 16'h0440;
  localparam logic [15:0] E_EX_ADDR    = 16'h0020;
  localparam logic [15:0] E_MEM_LD     = 16'hA000;
  localparam logic [15:0] E_MEM_ST     = 16'hE000;
  localparam logic [15:0] E_BR_TAKEN   = 16'h0904;
  localparam logic [15:0] E_BR_NOT     = 16'h0104;
  localparam logic [15:0] E_JAL        = 16'h0E80;
  localparam logic [15:0] E_HALT_DUMP  = 16'h0003;
  localparam logic [15:0] E_HALT       = 16'h0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          funct7b5 = 1'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_wr, addr_sel, ir_we, pc_we, reg_we;
  logic [1:0]    pc_src, wb_sel;
  logic          alu_src_b;
  logic [2:0]    alu_op;
  logic          createdump, halted;
  logic [IW-1:0] instret;
  logic [15:0]   outs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [15:0] exp;
    logic        retire;
  } vec_t;

  vec_t tbl[$];

  multicycle_ctrl #(.INSTRET_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .pc_src     (pc_src),
    .wb_sel     (wb_sel),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .createdump (createdump),
    .halted     (halted),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_wr, addr_sel, ir_we, pc_we, reg_we,
                 pc_src, wb_sel, alu_src_b, alu_op, createdump, halted};

  task automatic row(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy,
                     input logic [15:0] ex, input logic ret);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
    v.rdy = rdy; v.exp = ex; v.retire = ret;
    tbl.push_back(v);
  endtask

  // Change inputs on the falling edge, then let combinational outputs settle
  task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic rdy);
    @(negedge clk);
    rst = r; opcode = op; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic check_outs(input string nm, input logic [15:0] ex);
    checks++;
    if (outs !== ex) begin
      errors++;
      $display("FAIL outs %s: got %h required %h", nm, outs, ex);
    end
  endtask

  task automatic check_ir(input string nm, input logic [IW-1:0] ex);
    checks++;
    if (instret !== ex) begin
      errors++;
      $display("FAIL instret %s: got %0d required %0d", nm, instret, ex);
    end
  endtask

  task automatic check_excl(input string nm);
    checks++;
    if ((int'(ir_we) + int'(reg_we) + int'(mem_req & mem_wr)) > 1) begin
      errors++;
      $display("FAIL exclusive %s: ir_we=%b reg_we=%b memwrite=%b required at most one",
               nm, ir_we, reg_we, mem_req & mem_wr);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int ex);
    checks++;
    if (got != ex) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, ex);
    end
  endtask

  // One JAL from an idle FETCH, ending in FETCH-wait with the new count visible
  task automatic jal_instr(input logic [IW-1:0] ir_after);
    drive(1'b0, T_JAL, 3'd0, 1'b0, 1'b0, 1'b1); check_outs("jal_fetch", E_FETCH_RDY);
    drive(1'b0, T_JAL, 3'd0, 1'b0, 1'b0, 1'b0); check_outs("jal_dec", E_NONE);
    drive(1'b0, T_JAL, 3'd0, 1'b0, 1'b0, 1'b0); check_outs("jal_exec", E_JAL);
    drive(1'b0, T_JAL, 3'd0, 1'b0, 1'b0, 1'b0); check_outs("jal_refetch", E_FETCH_WAIT);
    check_ir("jal_after", ir_after);
  endtask

  initial begin
    logic [IW-1:0] exp_ir;
    int dump_cnt, mreq_cnt, halt_cnt;

    // R ADD, mem_ready high throughout (also ignored in DECODE/EXEC/WB)
    row("add_fetch", T_R, 3'b000, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("add_dec",   T_R, 3'b000, 1'b0, 1'b0, 1'b1, E_NONE,      1'b0);
    row("add_exec",  T_R, 3'b000, 1'b0, 1'b0, 1'b1, E_NONE,      1'b0);
    row("add_wb",    T_R, 3'b000, 1'b0, 1'b0, 1'b1, E_WB_ALU,    1'b1);
    // R SUB with one FETCH wait cycle
    row("sub_wait",  T_R, 3'b000, 1'b1, 1'b0, 1'b0, E_FETCH_WAIT, 1'b0);
    row("sub_fetch", T_R, 3'b000, 1'b1, 1'b0, 1'b1, E_FETCH_RDY,  1'b0);
    row("sub_dec",   T_R, 3'b000, 1'b1, 1'b0, 1'b0, E_NONE,       1'b0);
    row("sub_exec",  T_R, 3'b000, 1'b1, 1'b0, 1'b0, 16'h0004,     1'b0);
    row("sub_wb",    T_R, 3'b000, 1'b1, 1'b0, 1'b0, E_WB_ALU,     1'b1);
    // XORI: immediate operand, XOR code
    row("xori_fetch", T_I, 3'b100, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("xori_dec",   T_I, 3'b100, 1'b0, 1'b0, 1'b0, E_NONE,      1'b0);
    row("xori_exec",  T_I, 3'b100, 1'b0, 1'b0, 1'b0, 16'h0030,    1'b0);
    row("xori_wb",    T_I, 3'b100, 1'b0, 1'b0, 1'b0, E_WB_ALU,    1'b1);
    // R SRL
    row("srl_fetch", T_R, 3'b101, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("srl_dec",   T_R, 3'b101, 1'b0, 1'b0, 1'b0, E_NONE,      1'b0);
    row("srl_exec",  T_R, 3'b101, 1'b0, 1'b0, 1'b0, 16'h001C,    1'b0);
    row("srl_wb",    T_R, 3'b101, 1'b0, 1'b0, 1'b0, E_WB_ALU,    1'b1);
    // R AND
    row("and_fetch", T_R, 3'b111, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("and_dec",   T_R, 3'b111, 1'b0, 1'b0, 1'b0, E_NONE,      1'b0);
    row("and_exec",  T_R, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0008,    1'b0);
    row("and_wb",    T_R, 3'b111, 1'b0, 1'b0, 1'b0, E_WB_ALU,    1'b1);
    // ADDI with bit30 set: still ADD
    row("addi_fetch", T_I, 3'b000, 1'b1, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("addi_dec",   T_I, 3'b000, 1'b1, 1'b0, 1'b0, E_NONE,      1'b0);
    row("addi_exec",  T_I, 3'b000, 1'b1, 1'b0, 1'b0, E_EX_ADDR,   1'b0);
    row("addi_wb",    T_I, 3'b000, 1'b1, 1'b0, 1'b0, E_WB_ALU,    1'b1);
    // LOAD, memory answers after 3 wait cycles
    row("ld_fetch", T_LD, 3'b010, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("ld_dec",   T_LD, 3'b010, 1'b0, 1'b0, 1'b0, E_NONE,      1'b0);
    row("ld_exec",  T_LD, 3'b010, 1'b0, 1'b0, 1'b0, E_EX_ADDR,   1'b0);
    row("ld_mem0",  T_LD, 3'b010, 1'b0, 1'b0, 1'b0, E_MEM_LD,    1'b0);
    row("ld_mem1",  T_LD, 3'b010, 1'b0, 1'b0, 1'b0, E_MEM_LD,    1'b0);
    row("ld_mem2",  T_LD, 3'b010, 1'b0, 1'b0, 1'b0, E_MEM_LD,    1'b0);
    row("ld_mem3",  T_LD, 3'b010, 1'b0, 1'b0, 1'b1, E_MEM_LD,    1'b0);
    row("ld_wb",    T_LD, 3'b010, 1'b0, 1'b0, 1'b1, E_WB_MEM,    1'b1);
    // STORE; mem_ready in EXEC must not skip MEM
    row("st_fetch", T_ST, 3'b010, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("st_dec",   T_ST, 3'b010, 1'b0, 1'b0, 1'b1, E_NONE,      1'b0);
    row("st_exec",  T_ST, 3'b010, 1'b0, 1'b0, 1'b1, E_EX_ADDR,   1'b0);
    row("st_mem",   T_ST, 3'b010, 1'b0, 1'b0, 1'b1, E_MEM_ST,    1'b1);
    // Branches
    row("beq1_fetch", T_BR, 3'b000, 1'b0, 1'b1, 1'b1, E_FETCH_RDY, 1'b0);
    row("beq1_dec",   T_BR, 3'b000, 1'b0, 1'b1, 1'b0, E_NONE,      1'b0);
    row("beq1_exec",  T_BR, 3'b000, 1'b0, 1'b1, 1'b0, E_BR_TAKEN,  1'b1);
    row("beq0_fetch", T_BR, 3'b000, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("beq0_dec",   T_BR, 3'b000, 1'b0, 1'b0, 1'b0, E_NONE,      1'b0);
    row("beq0_exec",  T_BR, 3'b000, 1'b0, 1'b0, 1'b0, E_BR_NOT,    1'b1);
    row("bne0_fetch", T_BR, 3'b001, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("bne0_dec",   T_BR, 3'b001, 1'b0, 1'b0, 1'b0, E_NONE,      1'b0);
    row("bne0_exec",  T_BR, 3'b001, 1'b0, 1'b0, 1'b0, E_BR_TAKEN,  1'b1);
    row("bne1_fetch", T_BR, 3'b001, 1'b0, 1'b1, 1'b1, E_FETCH_RDY, 1'b0);
    row("bne1_dec",   T_BR, 3'b001, 1'b0, 1'b1, 1'b0, E_NONE,      1'b0);
    row("bne1_exec",  T_BR, 3'b001, 1'b0, 1'b1, 1'b0, E_BR_NOT,    1'b1);
    row("blt_fetch",  T_BR, 3'b100, 1'b0, 1'b1, 1'b1, E_FETCH_RDY, 1'b0);
    row("blt_dec",    T_BR, 3'b100, 1'b0, 1'b1, 1'b0, E_NONE,      1'b0);
    row("blt_exec",   T_BR, 3'b100, 1'b0, 1'b1, 1'b0, E_BR_NOT,    1'b1);
    // JAL
    row("jal_fetch", T_JAL, 3'b000, 1'b0, 1'b0, 1'b1, E_FETCH_RDY, 1'b0);
    row("jal_dec",   T_JAL, 3'b000, 1'b0, 1'b0, 1'b0, E_NONE,      1'b0);
    row("jal_exec",  T_JAL, 3'b000, 1'b0, 1'b0, 1'b0, E_JAL,       1'b1);

    // Reset: every output low while rst is high, even with inputs active
    drive(1'b1, T_ST, 3'b000, 1'b1, 1'b1, 1'b1); check_outs("rst_a", E_NONE); check_ir("rst_a", 4'd0);
    drive(1'b1, T_ST, 3'b000, 1'b1, 1'b1, 1'b1); check_outs("rst_b", E_NONE);
    drive(1'b0, T_R, 3'b000, 1'b0, 1'b0, 1'b0);  check_outs("post_rst_fetch", E_FETCH_WAIT);
    check_ir("post_rst", 4'd0);

    // Table of single-cycle vectors with a running retired-count model
    exp_ir = 4'd0;
    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].rdy);
      check_outs(tbl[i].name, tbl[i].exp);
      check_ir(tbl[i].name, exp_ir);
      check_excl(tbl[i].name);
      if (tbl[i].retire) exp_ir = exp_ir + 4'd1;
    end

    // Counter wrap: 14 retired so far, two more wrap a 4-bit counter to 0
    jal_instr(4'd15);
    jal_instr(4'd0);
    jal_instr(4'd1);

    // Reset in the middle of a STORE memory wait
    drive(1'b0, T_ST, 3'b010, 1'b0, 1'b0, 1'b1); check_outs("str_fetch", E_FETCH_RDY);
    drive(1'b0, T_ST, 3'b010, 1'b0, 1'b0, 1'b0); check_outs("str_dec", E_NONE);
    drive(1'b0, T_ST, 3'b010, 1'b0, 1'b0, 1'b0); check_outs("str_exec", E_EX_ADDR);
    drive(1'b0, T_ST, 3'b010, 1'b0, 1'b0, 1'b0); check_outs("str_mem_wait", E_MEM_ST);
    drive(1'b1, T_ST, 3'b010, 1'b0, 1'b0, 1'b1); check_outs("str_rst_a", E_NONE);
    drive(1'b1, T_ST, 3'b010, 1'b0, 1'b0, 1'b1); check_outs("str_rst_b", E_NONE);
    drive(1'b0, T_ST, 3'b010, 1'b0, 1'b0, 1'b0); check_outs("str_after_rst", E_FETCH_WAIT);
    check_ir("str_after_rst", 4'd0);

    // HALT opcode: one dump pulse, halted held, no memory traffic, count frozen
    jal_instr(4'd1);
    drive(1'b0, T_HLT, 3'b111, 1'b1, 1'b0, 1'b1); check_outs("hlt_fetch", E_FETCH_RDY);
    drive(1'b0, T_HLT, 3'b111, 1'b1, 1'b0, 1'b1); check_outs("hlt_dec", E_NONE);
    drive(1'b0, T_HLT, 3'b111, 1'b1, 1'b0, 1'b1); check_outs("hlt_entry", E_HALT_DUMP);
    dump_cnt = int'(createdump); mreq_cnt = int'(mem_req); halt_cnt = int'(halted);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, T_R, 3'b000, 1'b0, 1'b1, 1'b1);
      dump_cnt += int'(createdump);
      mreq_cnt += int'(mem_req);
      halt_cnt += int'(halted);
    end
    check_outs("hlt_steady", E_HALT);
    check_val("hlt_dump_pulses", dump_cnt, 1);
    check_val("hlt_mem_req_cycles", mreq_cnt, 0);
    check_val("hlt_halted_cycles", halt_cnt, 21);
    check_ir("hlt_frozen", 4'd1);
    drive(1'b1, T_R, 3'b000, 1'b0, 1'b0, 1'b0); check_outs("hlt_rst", E_NONE);
    drive(1'b0, T_R, 3'b000, 1'b0, 1'b0, 1'b0); check_outs("hlt_released", E_FETCH_WAIT);
    check_ir("hlt_released", 4'd0);

    // Unrecognized opcode also halts
    drive(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1); check_outs("ill_fetch", E_FETCH_RDY);
    drive(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0); check_outs("ill_dec", E_NONE);
    drive(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0); check_outs("ill_halt0", E_HALT_DUMP);
    drive(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1); check_outs("ill_halt1", E_HALT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
